// File: rtl/boot_loader_pkg.sv
// Shared constants and state encodings for the serial boot loader.
package boot_pkg;

    localparam logic [7:0] BOOT_SYNC = 8'hA5;
    localparam int         ADDR_W    = 16;
    localparam int         DATA_W    = 8;

    typedef enum logic [2:0] {
        LD_WAIT_SYNC,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_CHECK,
        LD_RUN
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    // A frame is in progress in every state except WaitSync and Run.
    function automatic logic ld_is_busy(input ld_state_t s);
        return !((s == LD_WAIT_SYNC) || (s == LD_RUN));
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Program-memory write port driven by the boot loader.
interface boot_loader_if;
    import boot_pkg::*;

    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (output prog_we, output prog_addr, output prog_data);
    modport slave  (input  prog_we, input  prog_addr, input  prog_data);

endinterface

// File: rtl/boot_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// centre sampling LSB first, one-cycle rx_valid at the stop-bit centre.
module uart_rx_byte
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       sync_rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Synchronize the asynchronous line and keep one extra stage for edge detection.
    // NOTE: these flops reset to 1 (line idle) so that leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit-timing state machine: detect start, re-check it mid-bit, shift data, sample stop.
    // NOTE: all state here uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            state    <= RX_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_END) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_BITS;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt  <= '0;
                        rx_valid <= 1'b1;
                        rx_ferr  <= !rx_sync;
                        rx_data  <= shift;
                        state    <= RX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: parses A5/LEN_HI/LEN_LO/data/CHK frames, writes data to
// program memory and releases the CPU once a frame's checksum is good.
// Optional build macro BOOT_TIMEOUT_EN adds an inter-byte timeout while busy.
module boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          uart_rx,
    boot_loader_if.master prog,
    output logic          cpu_run,
    output logic          busy,
    output logic          err
);

    if ((CLKS_PER_BIT < 4) || (TIMEOUT_CLKS < 1)) begin : g_param_check
        $error("boot_loader: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 1");
    end

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ferr;
    ld_state_t         state;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        sum;
    logic              timeout_hit;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .sync_rst (sync_rst),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

`ifdef BOOT_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign timeout_hit = busy && (to_cnt == 32'(TIMEOUT_CLKS - 1));

    // Inter-byte timer: restarts on every received byte, idles outside a frame.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            to_cnt <= '0;
        end else if (rx_valid || !busy) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Framing FSM with registered write port, run, busy and error outputs.
    always_ff @(posedge clk or negedge sync_rst) begin
        if (!sync_rst) begin
            state          <= LD_WAIT_SYNC;
            len            <= '0;
            addr           <= '0;
            sum            <= '0;
            prog.prog_we   <= 1'b0;
            prog.prog_addr <= '0;
            prog.prog_data <= '0;
            cpu_run        <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            prog.prog_we <= 1'b0;
            if (rx_valid && rx_ferr) begin
                // A corrupted byte aborts a frame in progress; elsewhere it is dropped.
                if (ld_is_busy(state)) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= LD_WAIT_SYNC;
                end
            end else if (rx_valid) begin
                case (state)
                    LD_WAIT_SYNC: begin
                        if (rx_data == BOOT_SYNC) begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= LD_LEN_HI;
                        end
                    end
                    LD_LEN_HI: begin
                        len[15:8] <= rx_data;
                        state     <= LD_LEN_LO;
                    end
                    LD_LEN_LO: begin
                        len[7:0] <= rx_data;
                        addr     <= '0;
                        sum      <= '0;
                        state    <= ({len[15:8], rx_data} == 16'd0) ? LD_CHECK : LD_DATA;
                    end
                    LD_DATA: begin
                        prog.prog_we   <= 1'b1;
                        prog.prog_addr <= addr;
                        prog.prog_data <= rx_data;
                        addr           <= addr + 1'b1;
                        sum            <= sum + rx_data;
                        if (addr == len - 16'd1) begin
                            state <= LD_CHECK;
                        end
                    end
                    LD_CHECK: begin
                        busy <= 1'b0;
                        if (8'(sum + rx_data) == 8'h00) begin
                            cpu_run <= 1'b1;
                            state   <= LD_RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= LD_WAIT_SYNC;
                        end
                    end
                    LD_RUN: begin
                        if (rx_data == BOOT_SYNC) begin
                            cpu_run <= 1'b0;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            state   <= LD_LEN_HI;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= LD_WAIT_SYNC;
                    end
                endcase
            end else if (timeout_hit) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= LD_WAIT_SYNC;
            end
        end
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial program loader that sits directly upstream of the CPU core. It receives a framed program image over an 8N1 UART line, writes each byte into program memory through a simple write port, and holds the CPU in reset until a frame with a valid checksum has been written. Once the image is accepted it releases the CPU by driving `cpu_run` high. `cpu_run` connects to the core's active-low reset input.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz, 115200 baud); minimum 4.
- `TIMEOUT_CLKS`, default 1_000_000: inter-byte timeout in cycles (only used when `BOOT_TIMEOUT_EN` is defined).
- `clk` in 1: system clock, rising edge.
- `sync_rst` in 1: reset, asynchronous assert, active-low.
- `uart_rx` in 1: serial input; idles high; asynchronous to `clk`.
- `prog_we` out 1: one-cycle program-memory write strobe.
- `prog_addr` out 16: write address.
- `prog_data` out 8: write data.
- `cpu_run` out 1: 1 = CPU released from reset.
- `busy` out 1: a frame is in progress (any state other than WaitSync or Run).
- `err` out 1: sticky error flag for the last frame.

## Operation
- Frame format: `0xA5`, LEN_HI, LEN_LO, LEN data bytes, CHK.
- A frame is valid when (sum of data bytes + CHK) mod 256 == 0.
- State machine:
  - WaitSync: receiving `0xA5` goes to LenHi and clears `err`; any other byte is ignored.
  - LenHi: latch length[15:8], go to LenLo.
  - LenLo: latch length[7:0]; go to Data, or to Check if length == 0.
  - Data: for each byte, write it at addr (addr starts at 0, +1 per byte) and add it to the 8-bit sum; after byte LEN-1 go to Check.
  - Check: if sum+CHK == 0, go to Run; otherwise set `err` and go to WaitSync.
  - Run: `cpu_run` = 1. Receiving `0xA5` drops `cpu_run`, clears `err`, and goes to LenHi (reload). Other bytes are ignored.
- Framing error (stop bit sampled 0): the byte is discarded. In WaitSync or Run the byte is simply ignored. In any other state, set `err` and go to WaitSync.
- Bytes already written by an aborted frame are not undone. `cpu_run` stays 0.
- Length 65535 is legal; the address counter never wraps within a frame.
- Reset values of all outputs are 0; state resets to WaitSync.
- Reset mid-frame aborts immediately and takes effect asynchronously.

## Timing
- `uart_rx` passes through a 2-flop synchronizer: 2 cycles of latency.
- Start detection is a high-to-low transition on the synchronized line. Start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the event is a glitch and is ignored.
- Data bits are sampled at bit centres, LSB first.
- `rx_valid` (internal) pulses for 1 cycle at the stop-bit centre sample.
- `prog_we`, `prog_addr`, and `prog_data` are registered and valid the cycle after `rx_valid`. `prog_we` is high for exactly 1 cycle per data byte.
- `cpu_run` rises the cycle after the `rx_valid` of a correct CHK byte. It falls the cycle after the `rx_valid` of a reload `0xA5`.
- `err` changes on the same cycle that the corresponding state transition takes effect.

## Configuration
- `BOOT_TIMEOUT_EN` defined:
  - A counter resets on every `rx_valid` and counts only while `busy`.
  - When it reaches TIMEOUT_CLKS, set `err` and go to WaitSync.
  - Run and WaitSync never time out.
- `BOOT_TIMEOUT_EN` undefined: no timeout counter exists; a stalled frame waits forever.

## Structure
- Package `boot_pkg`:
  - Sync byte constant `BOOT_SYNC = 8'hA5`.
  - Loader state enum (WaitSync, LenHi, LenLo, Data, Check, Run).
  - RX state enum (Idle, Start, Bits, Stop).
- Sub-module `uart_rx_byte` (params CLKS_PER_BIT): contains the synchronizer, bit timing, and shift register. Outputs `rx_data[7:0]`, `rx_valid`, `rx_ferr`.
- `boot_loader` contains the framing FSM, address counter, checksum, and timeout.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Send A5 00 03 11 22 33 9A -> writes (0,11) (1,22) (2,33), three `prog_we` pulses, then `cpu_run`=1, `err`=0.
- Same frame with CHK 9B -> three writes, `err`=1, `cpu_run`=0, `busy`=0; a following good frame clears `err` and sets `cpu_run`.
- Send A5 00 00 00 -> no `prog_we` pulses, `cpu_run`=1.
- Send 12 34 A5 00 01 7F 81 -> the leading bytes are ignored; single write (0,7F), `cpu_run`=1. A 2-cycle low glitch on `uart_rx` in idle produces no byte.
- Framing error on the 2nd data byte -> `err`=1, WaitSync, `cpu_run`=0.
- In Run, send A5 00 01 55 AB -> `cpu_run` falls, then write (0,55), then `cpu_run` rises.
- Assert `sync_rst` mid-Data -> all outputs 0 immediately.
- With `BOOT_TIMEOUT_EN` and TIMEOUT_CLKS=100, stop after LEN_HI -> `err`=1 at 100 cycles after the last `rx_valid`.
